// File: rtl/heapsort_batch_sequencer.sv
// Batch sequencer for the heap-sort priority-queue engine: pushes one batch of
// signed keys into the engine, then pops them back out in ascending order.
module heapsort_batch_sequencer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 6,
    parameter int CNT_W  = 3
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              eng_cmd_valid,
    output logic [1:0]        eng_cmd_op,
    output logic [DATA_W-1:0] eng_cmd_data,
    input  logic              eng_cmd_ready,
    input  logic              eng_rsp_valid,
    input  logic [DATA_W-1:0] eng_rsp_data,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [1:0]       OP_NOP  = 2'b00;
    localparam logic [1:0]       OP_PUSH = 2'b01;
    localparam logic [1:0]       OP_POP  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    state;
    state_t                    state_nx;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_nx;
    logic                      armed;
    logic                      pend;
    logic                      obuf_v;
    logic                      obuf_last;
    logic                      ovf;
    logic signed [DATA_W-1:0]  obuf;

    logic push_phase;
    logic room;
    logic push_req;
    logic push_fire;
    logic pop_req;
    logic pop_fire;
    logic rsp_take;
    logic out_fire;
    logic fills_up;

    // Command/handshake decode. armed holds the input side closed for the
    // first cycle after reset so every output reads 0 while reset is applied.
    always_comb begin
        push_phase = armed && (state == S_IDLE || state == S_LOAD);
        room       = (cnt < DEPTH_C);
        push_req   = push_phase && room && in_valid;
        in_ready   = push_phase && room && eng_cmd_ready;
        push_fire  = in_valid && in_ready;
        pop_req    = (state == S_DRAIN) && !obuf_v && !pend && (cnt != '0);
        pop_fire   = pop_req && eng_cmd_ready;
        rsp_take   = eng_rsp_valid && pend;
        out_fire   = obuf_v && out_ready;
        fills_up   = (cnt == DEPTH_C - 1'b1);
    end

    always_comb begin
        eng_cmd_valid = 1'b0;
        eng_cmd_op    = OP_NOP;
        eng_cmd_data  = '0;
        if (push_req) begin
            eng_cmd_valid = 1'b1;
            eng_cmd_op    = OP_PUSH;
            eng_cmd_data  = in_data;
        end else if (pop_req) begin
            eng_cmd_valid = 1'b1;
            eng_cmd_op    = OP_POP;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_LOAD: begin
                if (push_fire) begin
                    state_nx = (in_last || fills_up) ? S_DRAIN : S_LOAD;
                end
            end
            S_DRAIN: begin
                if (out_fire && obuf_last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_nx = cnt;
        if (push_fire) begin
            cnt_nx = cnt + 1'b1;
        end else if (pop_fire) begin
            cnt_nx = cnt - 1'b1;
        end
    end

    // ---- control register stage ----
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            armed     <= 1'b0;
            pend      <= 1'b0;
            obuf_v    <= 1'b0;
            obuf_last <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            armed <= 1'b1;

            if (pop_fire) begin
                pend <= 1'b1;
            end else if (rsp_take) begin
                pend <= 1'b0;
            end

            // A response only arrives while the buffer is empty, so capture
            // and drain never collide; cnt already excludes the popped key.
            if (rsp_take) begin
                obuf_v    <= 1'b1;
                obuf_last <= (cnt == '0);
            end else if (out_fire) begin
                obuf_v    <= 1'b0;
                obuf_last <= 1'b0;
            end

            if (push_fire && !in_last && fills_up) begin
                ovf <= 1'b1;
            end else if (push_fire && state == S_IDLE) begin
                ovf <= 1'b0;
            end
        end
    end

    // ---- output data stage ----
    always_ff @(posedge system1000) begin
        if (rsp_take) begin
            obuf <= $signed(eng_rsp_data);
        end
    end

    assign out_valid = obuf_v;
    assign out_data  = obuf;
    assign out_last  = obuf_last;
    assign busy      = (state != S_IDLE);
    assign count     = cnt;
    assign overflow  = ovf;

endmodule

// File: tb/tb_heapsort_batch_sequencer.sv
// Directed bench for heapsort_batch_sequencer with a behavioural min-heap
// engine model (one-cycle POP latency) and an output collector.
module tb_heapsort_batch_sequencer;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        eng_cmd_valid;
    logic [1:0]  eng_cmd_op;
    logic [31:0] eng_cmd_data;
    logic        eng_cmd_ready;
    logic        eng_rsp_valid;
    logic [31:0] eng_rsp_data;
    logic        busy;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    heapsort_batch_sequencer #(.DATA_W(32), .DEPTH(6), .CNT_W(3)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_last        (out_last),
        .out_ready       (out_ready),
        .eng_cmd_valid   (eng_cmd_valid),
        .eng_cmd_op      (eng_cmd_op),
        .eng_cmd_data    (eng_cmd_data),
        .eng_cmd_ready   (eng_cmd_ready),
        .eng_rsp_valid   (eng_rsp_valid),
        .eng_rsp_data    (eng_rsp_data),
        .busy            (busy),
        .count           (count),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: unordered store, POP returns the signed minimum next cycle.
    logic signed [31:0] mem [0:15];
    int    n_keys;
    int    mi;
    int    pushes;
    int    pops;
    logic  m_rsp_v;
    logic [31:0] m_rsp_d;
    logic  spur;

    always_comb begin
        mi = 0;
        for (int i = 1; i < 16; i++) begin
            if (i < n_keys && mem[i] < mem[mi]) mi = i;
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_keys  <= 0;
            m_rsp_v <= 1'b0;
        end else begin
            m_rsp_v <= 1'b0;
            if (eng_cmd_valid && eng_cmd_ready) begin
                if (eng_cmd_op == 2'b01 && n_keys < 16) begin
                    mem[n_keys] <= $signed(eng_cmd_data);
                    n_keys      <= n_keys + 1;
                    pushes      <= pushes + 1;
                end else if (eng_cmd_op == 2'b10) begin
                    pops    <= pops + 1;
                    m_rsp_v <= 1'b1;
                    if (n_keys > 0) begin
                        m_rsp_d         <= mem[mi];
                        mem[mi]         <= mem[n_keys-1];
                        n_keys          <= n_keys - 1;
                    end else begin
                        m_rsp_d <= 32'd0;
                    end
                end
            end
        end
    end

    assign eng_rsp_valid = m_rsp_v | spur;
    assign eng_rsp_data  = spur ? 32'd99 : m_rsp_d;

    // Output collector and POP-while-buffer-full watcher, sampled mid-cycle.
    int oq [$];
    bit lq [$];
    int viol;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            oq.push_back($signed(out_data));
            lq.push_back(out_last);
        end
        if (eng_cmd_valid && eng_cmd_op == 2'b10 && out_valid) viol <= viol + 1;
    end

    task automatic send_beat(input int d, input bit l, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_outs(input int num, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (oq.size() >= num) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b1; eng_cmd_ready = 1'b1; spur = 1'b0;
        pushes = 0; pops = 0; viol = 0;
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        checks++; if (eng_cmd_valid !== 1'b0 || eng_cmd_op !== 2'b00) begin errors++; $display("FAIL reset_cmd: got v=%b op=%b want 0/00", eng_cmd_valid, eng_cmd_op); end
        checks++; if (busy !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_state: got busy=%b count=%0d ovf=%b want 0/0/0", busy, count, overflow); end
        @(negedge clk);
        rstn = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic_batch;
        int  exp_d [4] = '{-3, 0, 5, 12};
        bit  exp_l [4] = '{0, 0, 0, 1};
        int  vals  [4] = '{5, -3, 12, 0};
        int  p0;
        bit  ok;
        oq.delete(); lq.delete();
        p0 = pushes;
        for (int i = 0; i < 4; i++) begin
            send_beat(vals[i], i == 3, ok);
            checks++; if (!ok) begin errors++; $display("FAIL basic_accept: beat %0d got timeout want accepted", i); end
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL basic_count_full: got %0d want 4", count); end
        wait_outs(4, ok);
        checks++; if (!ok || oq.size() != 4) begin errors++; $display("FAIL basic_out_count: got %0d want 4", oq.size()); end
        for (int i = 0; i < 4 && i < oq.size(); i++) begin
            checks++; if (oq[i] != exp_d[i] || lq[i] != exp_l[i]) begin errors++; $display("FAIL basic_out[%0d]: got %0d last=%b want %0d last=%b", i, oq[i], lq[i], exp_d[i], exp_l[i]); end
        end
        idle_cycles(2);
        checks++; if (pushes - p0 != 4) begin errors++; $display("FAIL basic_pushes: got %0d want 4", pushes - p0); end
        checks++; if (count !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL basic_end: got count=%0d busy=%b want 0/0", count, busy); end
    endtask

    task automatic test_single_beat;
        bit ok;
        oq.delete(); lq.delete();
        send_beat(7, 1'b1, ok);
        in_valid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL single_accept: got timeout want accepted"); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || eng_cmd_op !== 2'b10) begin errors++; $display("FAIL single_drain: got in_ready=%b busy=%b op=%b want 0/1/10", in_ready, busy, eng_cmd_op); end
        wait_outs(1, ok);
        checks++; if (!ok || oq.size() != 1 || oq[0] != 7 || lq[0] != 1'b1) begin errors++; $display("FAIL single_out: got n=%0d want one key 7 with last", oq.size()); end
        idle_cycles(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_overflow;
        int exp_d [7] = '{5, 6, 7, 8, 9, 10, 4};
        bit exp_l [7] = '{0, 0, 0, 0, 0, 1, 1};
        int p0;
        bit ok;
        oq.delete(); lq.delete();
        p0 = pushes;
        for (int i = 0; i < 6; i++) begin
            send_beat(10 - i, 1'b0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL ovf_accept: beat %0d got timeout want accepted", i); end
        end
        checks++; if (count !== 3'd6 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got count=%0d ovf=%b want 6/1", count, overflow); end
        in_valid = 1'b1; in_data = 4; in_last = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_stall: got in_ready=%b want 0", in_ready); end
        checks++; if (pushes - p0 != 6) begin errors++; $display("FAIL ovf_pushes: got %0d want 6", pushes - p0); end
        @(posedge clk); #1;
        send_beat(4, 1'b1, ok);
        in_valid = 1'b0;
        checks++; if (!ok || overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got ok=%b ovf=%b want 1/0", ok, overflow); end
        wait_outs(7, ok);
        checks++; if (!ok || oq.size() != 7) begin errors++; $display("FAIL ovf_out_count: got %0d want 7", oq.size()); end
        for (int i = 0; i < 7 && i < oq.size(); i++) begin
            checks++; if (oq[i] != exp_d[i] || lq[i] != exp_l[i]) begin errors++; $display("FAIL ovf_out[%0d]: got %0d last=%b want %0d last=%b", i, oq[i], lq[i], exp_d[i], exp_l[i]); end
        end
        idle_cycles(2);
    endtask

    task automatic test_backpressure;
        int  exp_d [3] = '{1, 2, 3};
        bit  pat   [4] = '{1, 0, 0, 1};
        int  vals  [3] = '{3, 1, 2};
        int  p0;
        int  v0;
        int  held;
        bit  ok;
        bit  prev_stall;
        oq.delete(); lq.delete();
        p0 = pops; v0 = viol; held = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(vals[i], i == 2, ok);
        in_valid = 1'b0;
        prev_stall = 1'b0;
        for (int c = 0; c < 80 && oq.size() < 3; c++) begin
            out_ready = pat[c % 4];
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || $signed(out_data) != held) begin errors++; $display("FAIL bp_stable: got v=%b d=%0d want 1/%0d", out_valid, $signed(out_data), held); end
            end
            prev_stall = out_valid && !out_ready;
            held = $signed(out_data);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        idle_cycles(2);
        checks++; if (oq.size() != 3) begin errors++; $display("FAIL bp_out_count: got %0d want 3", oq.size()); end
        for (int i = 0; i < 3 && i < oq.size(); i++) begin
            checks++; if (oq[i] != exp_d[i] || lq[i] != (i == 2)) begin errors++; $display("FAIL bp_out[%0d]: got %0d last=%b want %0d", i, oq[i], lq[i], exp_d[i]); end
        end
        checks++; if (pops - p0 != 3 || viol != v0) begin errors++; $display("FAIL bp_pops: got pops=%0d viol=%0d want 3/0", pops - p0, viol - v0); end
    endtask

    task automatic test_cmd_stall;
        int exp_d [5] = '{-8, -2, 1, 4, 15};
        int p0;
        bit ok;
        oq.delete(); lq.delete();
        p0 = pushes;
        send_beat(4, 1'b0, ok);
        send_beat(-8, 1'b0, ok);
        eng_cmd_ready = 1'b0; spur = 1'b1;
        in_valid = 1'b1; in_data = 15; in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0 || count !== 3'd2) begin errors++; $display("FAIL stall_cycle%0d: got in_ready=%b count=%0d want 0/2", i, in_ready, count); end
            @(posedge clk); #1;
            spur = 1'b0;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_spurious: got out_valid=%b want 0", out_valid); end
        eng_cmd_ready = 1'b1;
        send_beat(15, 1'b0, ok);
        send_beat(1, 1'b0, ok);
        send_beat(-2, 1'b1, ok);
        in_valid = 1'b0;
        wait_outs(5, ok);
        checks++; if (!ok || oq.size() != 5 || pushes - p0 != 5) begin errors++; $display("FAIL stall_counts: got outs=%0d pushes=%0d want 5/5", oq.size(), pushes - p0); end
        for (int i = 0; i < 5 && i < oq.size(); i++) begin
            checks++; if (oq[i] != exp_d[i] || lq[i] != (i == 4)) begin errors++; $display("FAIL stall_out[%0d]: got %0d last=%b want %0d", i, oq[i], lq[i], exp_d[i]); end
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_drain;
        int  vals [4] = '{9, -4, 6, 1};
        bit  ok;
        bit  seen;
        oq.delete(); lq.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(vals[i], i == 3, ok);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checks++; if (!seen || count !== 3'd3) begin errors++; $display("FAIL rst_pre: got out_valid=%b count=%0d want 1/3", seen, count); end
        rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_mid: got v=%b busy=%b count=%0d ovf=%b want 0/0/0/0", out_valid, busy, count, overflow); end
        @(posedge clk); #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        idle_cycles(1);
        oq.delete(); lq.delete();
        send_beat(2, 1'b0, ok);
        send_beat(-1, 1'b1, ok);
        in_valid = 1'b0;
        wait_outs(2, ok);
        checks++; if (!ok || oq.size() != 2) begin errors++; $display("FAIL rst_fresh_count: got %0d want 2", oq.size()); end
        else begin
            checks++; if (oq[0] != -1 || oq[1] != 2 || lq[0] != 1'b0 || lq[1] != 1'b1) begin errors++; $display("FAIL rst_fresh: got %0d,%0d want -1,2", oq[0], oq[1]); end
        end
        idle_cycles(2);
    endtask

    initial begin
        test_reset;
        test_basic_batch;
        test_single_beat;
        test_overflow;
        test_backpressure;
        test_cmd_stall;
        test_reset_mid_drain;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
